// File: rtl/gessd_div_n16_m10_pkg.sv
// Shared types and constants for the gESSD segmented approximate divider.
package gessd_div_n16_m10_pkg;

  localparam int unsigned GESSD_N = 16;
  localparam int unsigned GESSD_M = 10;
  localparam int unsigned CNT_W   = $clog2(2 * GESSD_M);
  localparam int unsigned SH_W    = $clog2(GESSD_N + 1);
  localparam int unsigned REM_W   = GESSD_M + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SEG_LO,
    SEG_MID,
    SEG_HI
  } seg_sel_t;

  // Left offset of the segment taken from an operand.
  function automatic logic [SH_W-1:0] seg_shift(input seg_sel_t sel);
    case (sel)
      SEG_HI:  return SH_W'(GESSD_N - GESSD_M);
      SEG_MID: return SH_W'(GESSD_N - GESSD_M - 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/gessd_div_n16_m10_if.sv
// Request/response handshake bundle for the gESSD divider.
interface gessd_div_n16_m10_if;
  import gessd_div_n16_m10_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [GESSD_N-1:0]   a;
  logic [GESSD_N-1:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [GESSD_N-1:0]   q;
  logic                 dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dz
  );

endinterface

// File: rtl/gessd_div_n16_m10_segment.sv
// Reduces an operand to an M-bit segment chosen by its leading bits.
module gessd_segment
  import gessd_div_n16_m10_pkg::*;
(
  input  logic [GESSD_N-1:0] i_x,
  output logic [GESSD_M-1:0] o_xs,
  output seg_sel_t           o_sel
);

  // Priority select: top bit, then any bit above the low segment, else low bits.
  always_comb begin
    o_sel = SEG_LO;
    o_xs  = i_x[GESSD_M-1:0];
    if (i_x[GESSD_N-1]) begin
      o_sel = SEG_HI;
      o_xs  = i_x[GESSD_N-1:GESSD_N-GESSD_M];
    end else if (|i_x[GESSD_N-2:GESSD_M]) begin
      o_sel = SEG_MID;
      o_xs  = i_x[GESSD_N-2:GESSD_N-GESSD_M-1];
    end
  end

endmodule

// File: rtl/gessd_div_n16_m10.sv
// Sequential approximate divider: segment both operands, restoring-divide
// the segments one bit per cycle, then rescale by the segment offsets.
module gessd_div_n16_m10
  import gessd_div_n16_m10_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  gessd_div_n16_m10_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * GESSD_M - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [REM_W-1:0]       r_rem;
  logic [2*GESSD_M-1:0]   r_quo;
  logic [GESSD_M-1:0]     r_bs;
  logic [SH_W-1:0]        r_shamt;
  logic                   r_zero;
  logic [GESSD_N-1:0]     r_q;
  logic                   r_dz;

  logic [GESSD_M-1:0]     w_as;
  logic [GESSD_M-1:0]     w_bs;
  seg_sel_t               w_sel_a;
  seg_sel_t               w_sel_b;
  logic [REM_W:0]         w_trial;
  logic [REM_W:0]         w_diff;
  logic                   w_ge;
  logic [REM_W-1:0]       w_rem_nxt;
  logic [2*GESSD_M-1:0]   w_quo_nxt;
  logic                   w_last;

  gessd_segment u_seg_a (
    .i_x   (bus.a),
    .o_xs  (w_as),
    .o_sel (w_sel_a)
  );

  gessd_segment u_seg_b (
    .i_x   (bus.b),
    .o_xs  (w_bs),
    .o_sel (w_sel_b)
  );

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The trial is one bit wider than the remainder so the compare never wraps.
  always_comb begin
    w_trial   = {r_rem, r_quo[2*GESSD_M-1]};
    w_diff    = w_trial - {2'b00, r_bs};
    w_ge      = (w_trial >= {2'b00, r_bs});
    w_rem_nxt = w_ge ? REM_W'(w_diff) : REM_W'(w_trial);
    w_quo_nxt = {r_quo[2*GESSD_M-2:0], w_ge};
    w_last    = (r_cnt == LAST_STEP);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = CALC;
      CALC:    if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state only; results come from registers.
  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
    bus.q         = r_q;
    bus.dz        = r_dz;
  end

  // Operand capture, iterative divide and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_bs    <= '0;
      r_shamt <= '0;
      r_zero  <= 1'b0;
      r_q     <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= {w_as, {GESSD_M{1'b0}}};
            r_bs    <= w_bs;
            r_shamt <= SH_W'(GESSD_M) + seg_shift(w_sel_b) - seg_shift(w_sel_a);
            r_zero  <= (w_bs == '0);
          end
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (w_last) begin
            r_q  <= r_zero ? '1 : GESSD_N'(w_quo_nxt >> r_shamt);
            r_dz <= r_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gessd_div_n16_m10.sv
// Directed bench for the gESSD approximate divider.
module tb_gessd_div_n16_m10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  gessd_div_n16_m10_if bus ();

  gessd_div_n16_m10 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request (called #1 after a rising edge) and check the result.
  task automatic run_req(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q, input logic exp_dz);
    int unsigned cyc;
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, 32'd20);
    check({tag, "_q"}, 32'(bus.q), 32'(exp_q));
    check({tag, "_dz"}, 32'(bus.dz), 32'(exp_dz));
    if (bus.out_ready) begin
      @(posedge clk); #1;
      check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_hold"}, 32'(bus.q), 32'(exp_q));
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("exact",   16'd100,   16'd7,     16'd14,    1'b0);
    run_req("hiseg",   16'h8000,  16'd3,     16'd10922, 1'b0);
    run_req("approx",  16'hFFFF,  16'h00FF,  16'd256,   1'b0);
    run_req("midseg",  16'h4000,  16'h0400,  16'd16,    1'b0);
    run_req("divzero", 16'd1234,  16'd0,     16'hFFFF,  1'b1);
    run_req("after0",  16'd9,     16'd3,     16'd3,     1'b0);
    run_req("zeroa",   16'd0,     16'd5,     16'd0,     1'b0);
    run_req("maxlo",   16'd1023,  16'd1,     16'd1023,  1'b0);
    run_req("hihi",    16'hFFFF,  16'hFFFF,  16'd1,     1'b0);
    run_req("shift16", 16'd1,     16'hFFFF,  16'd0,     1'b0);

    // Backpressure: result must hold and new requests must be ignored.
    bus.out_ready = 1'b0;
    run_req("bp", 16'd200, 16'd10, 16'd20, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'd50;
      bus.b = 16'd5;
      @(posedge clk); #1;
      check("bp_ov", 32'(bus.out_valid), 32'd1);
      check("bp_rdy", 32'(bus.in_ready), 32'd0);
      check("bp_q", 32'(bus.q), 32'd20);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ov", 32'(bus.out_valid), 32'd0);
    check("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    check("bp_rel_q", 32'(bus.q), 32'd20);
    @(posedge clk); #1;
    check("bp_single", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a calculation.
    bus.in_valid = 1'b1;
    bus.a = 16'd500;
    bus.b = 16'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ov", 32'(bus.out_valid), 32'd0);
    check("mrst_q", 32'(bus.q), 32'd0);
    check("mrst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_idle", 32'(bus.out_valid), 32'd0);
    run_req("postrst", 16'd81, 16'd9, 16'd9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
